// File: rtl/ycbcr_rgb565.sv
// Full-range BT.601 YCbCr to RGB565 converter.
// Three register stages: products, channel sums, clamp + pack.
// Syncs and data-valid travel through matching delay lines. The optional
// grayscale mode only changes at the start of a frame.
module ycbcr_rgb565 #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        YCbCr_hsync,
    input  logic        YCbCr_vsync,
    input  logic        YCbCr_de,
    input  logic [7:0]  Y_data,
    input  logic [7:0]  Cb_data,
    input  logic [7:0]  Cr_data,
    input  logic        gray_en,
    output logic        RGB_hsync,
    output logic        RGB_vsync,
    output logic        RGB_de,
    output logic [15:0] RGB_data
);

    // Channel offsets include the +128 rounding term ahead of the >>8.
    localparam logic signed [19:0] R_OFS = 20'sd45824;   // 45952 - 128
    localparam logic signed [19:0] G_OFS = 20'sd34816;   // 34688 + 128
    localparam logic signed [19:0] B_OFS = 20'sd57984;   // 58112 - 128

    logic               vsync_d;
    logic               gray_mode;
    logic [7:0]         cb_eff;
    logic [7:0]         cr_eff;

    logic signed [19:0] p_y;
    logic signed [19:0] p_r_cr;
    logic signed [19:0] p_g_cb;
    logic signed [19:0] p_g_cr;
    logic signed [19:0] p_b_cb;

    logic signed [19:0] r_sum;
    logic signed [19:0] g_sum;
    logic signed [19:0] b_sum;

    logic [7:0]         r8;
    logic [7:0]         g8;
    logic [7:0]         b8;

    logic [LATENCY-1:0] hs_sr;
    logic [LATENCY-1:0] vs_sr;
    logic [LATENCY-1:0] de_sr;

    // Arithmetic shift by 8, then saturate to 0..255. Bits [19:16] of a
    // non-negative sum being non-zero means the shifted value exceeds 255.
    function automatic logic [7:0] clamp8(input logic signed [19:0] s);
        if (s[19])
            return 8'd0;
        else if (s[18:16] != 3'd0)
            return 8'd255;
        else
            return s[15:8];
    endfunction

    // Grayscale forces chroma to its zero point so R = G = B = Y exactly.
    always_comb begin
        cb_eff = gray_mode ? 8'd128 : Cb_data;
        cr_eff = gray_mode ? 8'd128 : Cr_data;
    end

    // Frame-start detect; gray_mode only follows gray_en on a vsync rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d   <= 1'b0;
            gray_mode <= 1'b0;
        end else begin
            vsync_d <= YCbCr_vsync;
            if (YCbCr_vsync && !vsync_d)
                gray_mode <= gray_en;
        end
    end

    // Stage 1: per-component products.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_y    <= '0;
            p_r_cr <= '0;
            p_g_cb <= '0;
            p_g_cr <= '0;
            p_b_cb <= '0;
        end else begin
            p_y    <= $signed({4'b0, Y_data, 8'b0});
            p_r_cr <= $signed(20'(cr_eff) * 20'd359);
            p_g_cb <= $signed(20'(cb_eff) * 20'd88);
            p_g_cr <= $signed(20'(cr_eff) * 20'd183);
            p_b_cb <= $signed(20'(cb_eff) * 20'd454);
        end
    end

    // Stage 2: channel sums, wide enough that nothing wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            g_sum <= '0;
            b_sum <= '0;
        end else begin
            r_sum <= p_y + p_r_cr - R_OFS;
            g_sum <= p_y - p_g_cb - p_g_cr + G_OFS;
            b_sum <= p_y + p_b_cb - B_OFS;
        end
    end

    // Saturated 8-bit channels feeding the pack stage.
    always_comb begin
        r8 = clamp8(r_sum);
        g8 = clamp8(g_sum);
        b8 = clamp8(b_sum);
    end

    // Low bits dropped by the 565 pack are intentionally discarded.
    logic unused_low;
    assign unused_low = ^{r8[2:0], g8[1:0], b8[2:0]};

    // Stage 3: pack to RGB565, blanking pixels outside the active region.
    always_ff @(posedge clk) begin
        if (rst)
            RGB_data <= 16'h0000;
        else if (de_sr[LATENCY-2])
            RGB_data <= {r8[7:3], g8[7:2], b8[7:3]};
        else
            RGB_data <= 16'h0000;
    end

    // Sync and data-valid delay lines matching the datapath depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_sr <= '0;
            vs_sr <= '0;
            de_sr <= '0;
        end else begin
            hs_sr <= {hs_sr[LATENCY-2:0], YCbCr_hsync};
            vs_sr <= {vs_sr[LATENCY-2:0], YCbCr_vsync};
            de_sr <= {de_sr[LATENCY-2:0], YCbCr_de};
        end
    end

    assign RGB_hsync = hs_sr[LATENCY-1];
    assign RGB_vsync = vs_sr[LATENCY-1];
    assign RGB_de    = de_sr[LATENCY-1];

endmodule

// File: tb/tb_ycbcr_rgb565.sv
// Scoreboard bench for ycbcr_rgb565: the driver pushes hand-computed pixels,
// and the monitor checks sync alignment, blanking and pixel data/latency.
module tb_ycbcr_rgb565;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs, vs, de, gray;
    logic [7:0]  y, cb, cr;
    logic        o_hs, o_vs, o_de;
    logic [15:0] o_data;

    always #5 clk = ~clk;

    ycbcr_rgb565 dut (
        .clk         (clk),
        .rst         (rst),
        .YCbCr_hsync (hs),
        .YCbCr_vsync (vs),
        .YCbCr_de    (de),
        .Y_data      (y),
        .Cb_data     (cb),
        .Cr_data     (cr),
        .gray_en     (gray),
        .RGB_hsync   (o_hs),
        .RGB_vsync   (o_vs),
        .RGB_de      (o_de),
        .RGB_data    (o_data)
    );

    typedef struct {
        logic [15:0] data;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   h_rst [0:4095];
    bit   h_hs  [0:4095];
    bit   h_vs  [0:4095];
    bit   h_de  [0:4095];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Apply one cycle of inputs; a reset cycle cancels pixels that would still be in flight.
    task automatic drive(input bit r, input bit h, input bit v, input bit d, input bit g,
                         input logic [7:0] yy, input logic [7:0] cbb, input logic [7:0] crr,
                         input logic [15:0] exp);
        rst = r; hs = h; vs = v; de = d; gray = g; y = yy; cb = cbb; cr = crr;
        if (r)
            while (sb.size() > 0 && sb[$].tag >= edge_cnt - 1) sb.pop_back();
        @(posedge clk);
        #1;
        h_rst[edge_cnt] = r;
        h_hs[edge_cnt]  = h;
        h_vs[edge_cnt]  = v;
        h_de[edge_cnt]  = d;
        if (d && !r) sb.push_back('{exp, edge_cnt});
    endtask

    // Monitor: outputs after edge e reflect inputs sampled at edge e-2 unless reset intervened.
    initial begin
        exp_t ent;
        int   e;
        bit   kill;
        forever begin
            @(posedge clk);
            #2;
            e = edge_cnt;
            if (e >= 3 && e < 4096) begin
                kill = h_rst[e] | h_rst[e-1] | h_rst[e-2];
                check("hsync_align", {31'b0, o_hs}, {31'b0, kill ? 1'b0 : h_hs[e-2]});
                check("vsync_align", {31'b0, o_vs}, {31'b0, kill ? 1'b0 : h_vs[e-2]});
                check("de_align",    {31'b0, o_de}, {31'b0, kill ? 1'b0 : h_de[e-2]});
                if (o_de === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("pixel_expected", 32'(sb.size()), 32'd1);
                    end else begin
                        ent = sb.pop_front();
                        check("rgb_data", {16'b0, o_data}, {16'b0, ent.data});
                        check("latency", 32'(e - ent.tag), 32'd2);
                    end
                end else begin
                    check("blank_data", {16'b0, o_data}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    logic [7:0]  vy  [0:4] = '{8'd128, 8'd255, 8'd255, 8'd0,  8'd200};
    logic [7:0]  vcb [0:4] = '{8'd128, 8'd128, 8'd255, 8'd0,  8'd0};
    logic [7:0]  vcr [0:4] = '{8'd128, 8'd255, 8'd128, 8'd0,  8'd255};
    logic [15:0] vex [0:4] = '{16'h8410, 16'hFD3F, 16'hFE9F, 16'h0440, 16'hFCC0};

    initial begin
        // Reset, outputs must read zero.
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 8'd77, 8'd33, 8'd99, 16'h0);

        // Directed colour vectors, with a de=0 gap carrying non-zero data.
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0, vy[i], vcb[i], vcr[i], vex[i]);
            drive(0, 1, 0, 0, 0, 8'd255, 8'd255, 8'd255, 16'h0);
        end
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, vy[i], vcb[i], vcr[i], vex[i]);

        // Random sync/de pattern on mid-gray pixels.
        for (int i = 0; i < 40; i++)
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  0, 8'd128, 8'd128, 8'd128, 16'h8410);

        // Grayscale selected at a vsync rise; a mid-frame toggle is ignored.
        drive(0, 0, 0, 0, 1, 8'd0, 8'd0, 8'd0, 16'h0);
        drive(0, 0, 1, 0, 1, 8'd255, 8'd0, 8'd255, 16'h0);
        drive(0, 0, 1, 1, 1, 8'd200, 8'd0, 8'd255, 16'hCE59);
        drive(0, 0, 0, 1, 0, 8'd200, 8'd0, 8'd255, 16'hCE59);
        drive(0, 0, 0, 1, 0, 8'd200, 8'd0, 8'd255, 16'hCE59);
        drive(0, 0, 1, 1, 0, 8'd200, 8'd0, 8'd255, 16'hCE59);
        drive(0, 0, 1, 1, 0, 8'd200, 8'd0, 8'd255, 16'hFCC0);
        drive(0, 0, 0, 0, 0, 8'd0, 8'd0, 8'd0, 16'h0);

        // Continuous pixels with a 2-cycle reset; vsync is held high across release.
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0, vy[i % 5], vcb[i % 5], vcr[i % 5], vex[i % 5]);
        drive(1, 0, 1, 1, 1, 8'd255, 8'd255, 8'd255, 16'h0);
        drive(1, 0, 1, 1, 1, 8'd255, 8'd255, 8'd255, 16'h0);
        drive(0, 0, 1, 1, 1, 8'd200, 8'd0, 8'd255, 16'hFCC0);
        drive(0, 0, 1, 1, 1, 8'd200, 8'd0, 8'd255, 16'hCE59);
        drive(0, 0, 0, 1, 1, 8'd128, 8'd0, 8'd255, 16'h8410);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 1, 8'd10, 8'd20, 8'd30, 16'h0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ycbcr_rgb565.md
YCBCR_RGB565 -- requirements
Module: ycbcr_rgb565

Interface
REQ-001 SHALL have port clk, input, 1 bit: pixel clock; all logic is on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports YCbCr_hsync / YCbCr_vsync / YCbCr_de, each input, 1 bit: input line sync, frame sync and data-valid.
REQ-004 SHALL have ports Y_data / Cb_data / Cr_data, each input, 8 bits: full-range BT.601 components, unsigned, with 128 as chroma zero.
REQ-005 SHALL have port gray_en, input, 1 bit: request to ignore chroma (R=G=B=Y); quasi-static.
REQ-006 SHALL have ports RGB_hsync / RGB_vsync / RGB_de, each output, 1 bit: delayed copies of the input syncs and data-valid.
REQ-007 SHALL have port RGB_data, output, 16 bits: RGB565 packed as {R[7:3], G[7:2], B[7:3]}.
REQ-008 SHALL have parameter LATENCY, default 3, giving the pipeline depth; it is fixed and SHALL NOT be overridden.

Function
REQ-009 SHALL compute, per pixel, the following with all intermediate values signed and at least 18 bits wide:
- Rs = 256*Y + 359*Cr - 45952 + 128
- Gs = 256*Y - 88*Cb - 183*Cr + 34688 + 128
- Bs = 256*Y + 454*Cb - 58112 + 128
REQ-010 SHALL form each 8-bit channel as the arithmetic right shift by 8 of its sum, clamped: negative -> 0, greater than 255 -> 255.
REQ-011 SHALL pipeline the datapath as: stage 1 registers the products; stage 2 registers the three sums; stage 3 registers the clamp and RGB565 pack.
REQ-012 SHALL present each pixel's RGB_data exactly 3 clk after its inputs are sampled.
REQ-013 SHALL delay YCbCr_hsync, YCbCr_vsync and YCbCr_de through 3-deep shift registers so they stay aligned with RGB_data.
REQ-014 SHALL drive RGB_data to 16'h0000 in stage 3 whenever the stage-3 delayed de is 0.
REQ-015 SHALL register YCbCr_vsync each cycle as vsync_d, and detect a frame start when YCbCr_vsync=1 and vsync_d=0.
REQ-016 SHALL load gray_mode from gray_en on the clk edge at which a frame start is detected; gray_mode SHALL hold its value at all other times.
REQ-017 SHALL take gray_mode from the register value, so the change applies to pixels sampled from the cycle after the frame-start edge onward.
REQ-018 SHALL substitute Cb=Cr=128 at the stage-1 input while gray_mode=1, giving R=G=B=Y exactly.
REQ-019 SHALL ignore changes of gray_en mid-frame until the next frame start.
REQ-020 SHALL continue to compute on Y/Cb/Cr when de=0; only the output zeroing of REQ-014 applies to those pixels.
REQ-021 SHALL NOT wrap in any arithmetic; the clamp is the only saturation point.
REQ-022 SHALL accept back-to-back pixels every clk, with no stall or backpressure.

Reset
REQ-023 SHALL, while rst=1 at a clk edge, clear to 0 all product, sum and pack registers, all sync/de shift registers, vsync_d and gray_mode.
REQ-024 SHALL hold RGB_data=0 and RGB_hsync=RGB_vsync=RGB_de=0 from the first clk edge with rst=1 until reset is released.
REQ-025 SHALL, when rst is asserted mid-frame, discard every in-flight pixel with no partial outputs after release.
REQ-026 SHALL, after rst is released, produce the first valid output 3 clk after the first input sampled with de=1.
REQ-027 SHALL treat a vsync held high through reset release as a frame start on the first post-reset edge, because vsync_d resets to 0.

Verification
REQ-028 SHALL cover mid gray: Y=128, Cb=128, Cr=128, de=1, gray_mode=0 -> RGB_data=16'h8410 and RGB_de=1, 3 clk later.
REQ-029 SHALL cover clamp high: Y=255, Cb=128, Cr=255 -> R clamps to 255, G=164 -> RGB_data=16'hFD3F; and Y=255, Cb=255, Cr=128 -> 16'hFE9F.
REQ-030 SHALL cover clamp low: Y=0, Cb=0, Cr=0 -> R=0, G=136, B=0 -> RGB_data=16'h0440.
REQ-031 SHALL cover gray mode: gray_en=1 before a vsync rising edge, then Y=200, Cb=0, Cr=255 -> RGB_data=16'hCE59; toggling gray_en mid-frame does not change the output until the next vsync rise.
REQ-032 SHALL cover sync alignment: a random hsync/vsync/de pattern -> outputs equal the inputs delayed exactly 3 clk, and RGB_data=0 wherever RGB_de=0.
REQ-033 SHALL cover reset mid-stream: continuous pixels with rst pulsed high for 2 clk -> all outputs 0 during reset, no stale pixel after release, first valid pixel 3 clk after the first post-reset de.
